// File: rtl/operand_skewer.sv
// operand_skewer: buffers one ROWS x DEPTH operand tile and streams it into ROWS lanes with diagonal skew.
// Option SKEW_REPLAY_EN: keep the tile after streaming, replay on go, flush port starts a new load.
module operand_skewer #(
  parameter int data_size = 8,
  parameter int ROWS = 4,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [data_size-1:0]      in_data,
  input  logic                      go,
`ifdef SKEW_REPLAY_EN
  input  logic                      flush,
`endif
  output logic                      tile_full,
  output logic [ROWS*data_size-1:0] out_a,
  output logic                      out_valid,
  output logic                      done
);
  localparam int N = ROWS*DEPTH;
  localparam int CW = $clog2(N+1);
  localparam int TW = $clog2(ROWS+DEPTH);
  localparam logic [CW-1:0] C_LAST = CW'(N-1);
  localparam logic [TW-1:0] T_LAST = TW'(ROWS+DEPTH-2);
  typedef enum logic [1:0] {LOAD, READY, STREAM} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [TW-1:0] t, t_n, tn;
  logic [data_size-1:0] buf_q [N];
  logic [ROWS*data_size-1:0] lanes, out_n;
  logic rdy_n, full_n, ov_n, done_n, accept;
  assign accept = state == LOAD && in_valid && in_ready;
  // stream cycle whose lane values are registered at the coming edge
  assign tn = state == READY ? '0 : t + 1'b1;
  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (accept && cnt == CW'(i)) buf_q[i] <= in_data;
  always_comb begin
    lanes = '0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < DEPTH; k++)
        if (int'(tn) - r == k) lanes[r*data_size +: data_size] = buf_q[r*DEPTH+k];
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    t_n = t;
    out_n = '0;
    ov_n = 1'b0;
    done_n = 1'b0;
    rdy_n = 1'b0;
    full_n = tile_full;
    case (state)
      LOAD: begin
        rdy_n = 1'b1;
        if (accept) begin
          cnt_n = cnt + 1'b1;
          if (cnt == C_LAST) begin
            state_n = READY;
            rdy_n = 1'b0;
            full_n = 1'b1;
          end
        end
      end
      READY: begin
        full_n = 1'b1;
`ifdef SKEW_REPLAY_EN
        if (flush) begin
          state_n = LOAD;
          cnt_n = '0;
          full_n = 1'b0;
          rdy_n = 1'b1;
        end else
`endif
        if (go) begin
          state_n = STREAM;
          full_n = 1'b0;
          t_n = '0;
          out_n = lanes;
          ov_n = 1'b1;
        end
      end
      STREAM: begin
        if (t == T_LAST) begin
          done_n = 1'b1;
`ifdef SKEW_REPLAY_EN
          state_n = READY;
          full_n = 1'b1;
`else
          state_n = LOAD;
          cnt_n = '0;
          rdy_n = 1'b1;
`endif
        end else begin
          t_n = t + 1'b1;
          out_n = lanes;
          ov_n = 1'b1;
        end
      end
      default: state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= LOAD;
      cnt <= '0;
      t <= '0;
      out_a <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
      tile_full <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      t <= t_n;
      out_a <= out_n;
      out_valid <= ov_n;
      done <= done_n;
      tile_full <= full_n;
      in_ready <= rdy_n;
    end
endmodule

// File: tb/tb_operand_skewer.sv
// tb_operand_skewer: randomized and directed checks of operand_skewer against a scatter model of the skewed tile.
module tb_operand_skewer;
  localparam int W = 8;
  localparam int R = 4;
  localparam int D = 4;
  localparam int N = R*D;
  localparam int L = R+D-1;
`ifdef SKEW_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif
  logic clk = 0, reset = 0, in_valid = 0, go = 0, flush = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, tile_full, out_valid, done;
  logic [R*W-1:0] out_a;
  logic in_valid1 = 0, go1 = 0, flush1 = 0;
  logic [W-1:0] in_data1 = '0;
  logic in_ready1, tile_full1, out_valid1, done1;
  logic [W-1:0] out_a1;
  int total = 0, bad = 0;
  logic [W-1:0] tile [N];
  logic [R*W-1:0] exp_s [L];
  logic [R*W-1:0] seen [L];

  always #5 clk = ~clk;

  operand_skewer #(.data_size(W), .ROWS(R), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .go(go),
`ifdef SKEW_REPLAY_EN
    .flush(flush),
`endif
    .tile_full(tile_full), .out_a(out_a), .out_valid(out_valid), .done(done));

  operand_skewer #(.data_size(W), .ROWS(1), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .go(go1),
`ifdef SKEW_REPLAY_EN
    .flush(flush1),
`endif
    .tile_full(tile_full1), .out_a(out_a1), .out_valid(out_valid1), .done(done1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // each element (r,k) lands on lane r at stream cycle r+k; every other slot is zero
  function automatic void build_expect();
    for (int t = 0; t < L; t++) exp_s[t] = '0;
    for (int r = 0; r < R; r++)
      for (int k = 0; k < D; k++)
        exp_s[r+k][r*W +: W] = tile[r*D+k];
  endfunction

  task automatic to_load();
`ifdef SKEW_REPLAY_EN
    flush = 1;
    step();
    flush = 0;
`endif
  endtask

  task automatic fill_count();
    for (int i = 0; i < N; i++) tile[i] = W'(i+1);
  endtask

  task automatic load_tile(input bit gaps, input bit chk_idle);
    bit ok;
    for (int w = 0; w < N; w++) begin
      in_data = tile[w];
      ok = 0;
      for (int n = 0; n < 100 && !ok; n++) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        ok = in_valid && in_ready;
        if (chk_idle) begin
          total++;
          if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_during_load word %0d: out_valid=%b want 0", w, out_valid);
          end
        end
        step();
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL load_timeout word %0d: in_ready=%b want 1", w, in_ready);
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    build_expect();
    total++;
    if (tile_full !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL loaded: tile_full=%b in_ready=%b out_valid=%b want 1 0 0", tile_full, in_ready, out_valid);
    end
  endtask

  task automatic pulse_go();
    go = 1;
    step();
    go = 0;
  endtask

  task automatic check_stream(input string name);
    for (int t = 0; t < L; t++) begin
      seen[t] = out_a;
      total++;
      if (out_valid !== 1'b1 || out_a !== exp_s[t] || done !== 1'b0) begin
        bad++;
        $display("FAIL %s t%0d: out_valid=%b out_a=%h done=%b want 1 %h 0", name, t, out_valid, out_a, done, exp_s[t]);
      end
      step();
    end
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0 || out_a !== '0 || in_ready !== !REPLAY || tile_full !== REPLAY) begin
      bad++;
      $display("FAIL %s end: done=%b out_valid=%b out_a=%h in_ready=%b tile_full=%b want 1 0 0 %b %b",
               name, done, out_valid, out_a, in_ready, tile_full, !REPLAY, REPLAY);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse: done=%b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    step();
    step();
    total++;
    if (out_a !== '0 || out_valid !== 1'b0 || done !== 1'b0 || tile_full !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: out_a=%h ov=%b done=%b full=%b rdy=%b want all 0", out_a, out_valid, done, tile_full, in_ready);
    end
    reset = 1;
    total++;
    if (in_ready !== 1'b0 || in_ready1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_ready: in_ready=%b in_ready1=%b want 0 0", in_ready, in_ready1);
    end
    step();
    total++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1 || tile_full !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ready_after_reset: in_ready=%b in_ready1=%b full=%b ov=%b want 1 1 0 0", in_ready, in_ready1, tile_full, out_valid);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] v;
    for (int i = 0; i < 2; i++) begin
      v = i == 0 ? W'(7) : W'($urandom);
      if (i != 0) begin
`ifdef SKEW_REPLAY_EN
        flush1 = 1;
        step();
        flush1 = 0;
`endif
      end
      in_valid1 = 1;
      in_data1 = v;
      step();
      in_valid1 = 0;
      total++;
      if (tile_full1 !== 1'b1 || in_ready1 !== 1'b0) begin
        bad++;
        $display("FAIL single_loaded: full=%b rdy=%b want 1 0", tile_full1, in_ready1);
      end
      go1 = 1;
      step();
      go1 = 0;
      total++;
      if (out_valid1 !== 1'b1 || out_a1 !== v) begin
        bad++;
        $display("FAIL single_stream: ov=%b out=%h want 1 %h", out_valid1, out_a1, v);
      end
      step();
      total++;
      if (done1 !== 1'b1 || out_valid1 !== 1'b0 || out_a1 !== '0 || in_ready1 !== !REPLAY) begin
        bad++;
        $display("FAIL single_done: done=%b ov=%b out=%h rdy=%b want 1 0 0 %b", done1, out_valid1, out_a1, in_ready1, !REPLAY);
      end
    end
  endtask

  task automatic test_basic();
    to_load();
    fill_count();
    load_tile(0, 0);
    pulse_go();
    check_stream("basic");
    total++;
    if (seen[0] !== 32'h00000001 || seen[1] !== 32'h00000502 || seen[3] !== 32'h0d0a0704 || seen[6] !== 32'h10000000) begin
      bad++;
      $display("FAIL basic_literal: t0=%h t1=%h t3=%h t6=%h want 00000001 00000502 0d0a0704 10000000", seen[0], seen[1], seen[3], seen[6]);
    end
  endtask

  task automatic test_hold_invalid();
    to_load();
    fill_count();
    load_tile(0, 0);
    in_valid = 1;
    in_data = 8'd99;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (in_ready !== 1'b0 || tile_full !== 1'b1) begin
        bad++;
        $display("FAIL hold_extra_word %0d: in_ready=%b full=%b want 0 1", i, in_ready, tile_full);
      end
    end
    in_valid = 0;
    pulse_go();
    check_stream("hold_invalid");
  endtask

  task automatic test_go_during_load();
    to_load();
    for (int i = 0; i < N; i++) tile[i] = W'($urandom);
    go = 1;
    load_tile(1, 1);
    step();
    go = 0;
    check_stream("go_during_load");
  endtask

  task automatic test_reset_mid_stream();
    to_load();
    fill_count();
    load_tile(0, 0);
    pulse_go();
    step();
    step();
    step();
    reset = 0;
    step();
    reset = 1;
    total++;
    if (out_a !== '0 || out_valid !== 1'b0 || done !== 1'b0 || tile_full !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: out_a=%h ov=%b done=%b full=%b rdy=%b want all 0", out_a, out_valid, done, tile_full, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_quiet %0d: done=%b ov=%b want 0 0", i, done, out_valid);
      end
    end
    load_tile(0, 0);
    pulse_go();
    check_stream("after_reset");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 5; n++) begin
      to_load();
      for (int i = 0; i < N; i++) tile[i] = W'($urandom);
      load_tile(1, 0);
      repeat ($urandom_range(0, 3)) step();
      pulse_go();
      check_stream("random");
    end
  endtask

`ifdef SKEW_REPLAY_EN
  task automatic test_replay();
    to_load();
    for (int i = 0; i < N; i++) tile[i] = W'($urandom);
    load_tile(0, 0);
    pulse_go();
    check_stream("replay_first");
    pulse_go();
    check_stream("replay_second");
    flush = 1;
    step();
    flush = 0;
    total++;
    if (in_ready !== 1'b1 || tile_full !== 1'b0) begin
      bad++;
      $display("FAIL flush: in_ready=%b full=%b want 1 0", in_ready, tile_full);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_basic();
    test_hold_invalid();
    test_go_during_load();
    test_reset_mid_stream();
    test_back_to_back();
`ifdef SKEW_REPLAY_EN
    test_replay();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
